// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the multi-master RAM arbiter.
// Strobe constants describe the RAM pins when no master owns the bus.
package ram_arb_pkg;

   typedef enum logic {
      ARB_FIXED = 1'b0,
      ARB_RR    = 1'b1
   } arb_mode_e;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      GRANT    = 2'd1,
      HANDOVER = 2'd2
   } arb_state_e;

   localparam logic RAM_CS_OFF  = 1'b0;
   localparam logic RAM_WEN_OFF = 1'b1;
   localparam logic RAM_OEN_OFF = 1'b1;

endpackage

// File: rtl/arb_picker.sv
// Rotating-base priority encoder: returns the first set request at or
// after i_base, wrapping modulo NUM_MASTERS. Base 0 gives fixed priority.
module arb_picker #(
   parameter int  NUM_MASTERS = 4,
   localparam int IDX_W       = $clog2(NUM_MASTERS)
) (
   input  logic [NUM_MASTERS-1:0] i_req,
   input  logic [IDX_W-1:0]       i_base,
   output logic                   o_valid,
   output logic [IDX_W-1:0]       o_index
);

   logic [IDX_W:0]   w_sum;
   logic [IDX_W-1:0] w_idx;

   // Scan from the farthest offset down so the nearest match is written last.
   always_comb begin
      o_valid = 1'b0;
      o_index = '0;
      w_sum   = '0;
      w_idx   = '0;
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
         w_sum = {1'b0, i_base} + (IDX_W+1)'(i);
         if (w_sum >= (IDX_W+1)'(NUM_MASTERS)) begin
            w_sum = w_sum - (IDX_W+1)'(NUM_MASTERS);
         end
         w_idx = w_sum[IDX_W-1:0];
         if (i_req[w_idx]) begin
            o_valid = 1'b1;
            o_index = w_idx;
         end
      end
   end

endmodule

// File: rtl/ram_arbiter_mm.sv
// Multi-master single-port RAM arbiter with fixed or round-robin policy,
// a dead cycle at every ownership change and an advisory hold-limit yield.
module ram_arbiter_mm
   import ram_arb_pkg::*;
#(
   parameter int        NUM_MASTERS = 4,
   parameter int        ADDR_W      = 8,
   parameter int        DATA_W      = 8,
   parameter arb_mode_e ARB_MODE    = ARB_FIXED,
   parameter int        MAX_HOLD    = 0,
   localparam int       IDX_W       = $clog2(NUM_MASTERS)
) (
   input  logic                          Clk,
   input  logic                          Rst,
   input  logic [NUM_MASTERS-1:0]        M_Req,
   input  logic [NUM_MASTERS-1:0]        M_Idle,
   output logic [NUM_MASTERS-1:0]        M_Grant,
   output logic [NUM_MASTERS-1:0]        M_Yield,
   input  logic [NUM_MASTERS*ADDR_W-1:0] M_Address,
   input  logic [NUM_MASTERS*DATA_W-1:0] M_DataOut,
   input  logic [NUM_MASTERS-1:0]        M_Cs,
   input  logic [NUM_MASTERS-1:0]        M_Wen,
   input  logic [NUM_MASTERS-1:0]        M_Oen,
   output logic [ADDR_W-1:0]             RAM_Address,
   output logic [DATA_W-1:0]             RAM_DataIn,
   output logic                          RAM_Cs,
   output logic                          RAM_Wen,
   output logic                          RAM_Oen,
   output logic [IDX_W-1:0]              Owner,
   output logic                          Busy,
   output logic [1:0]                    o_dbg_state
);

   localparam int              HOLD_W   = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

   arb_state_e             r_state;
   arb_state_e             w_next_state;
   logic [IDX_W-1:0]       r_owner;
   logic [IDX_W-1:0]       r_rr_ptr;
   logic [HOLD_W-1:0]      r_hold_cnt;
   logic [NUM_MASTERS-1:0] r_grant;
   logic [NUM_MASTERS-1:0] r_yield;

   logic                   w_pick_valid;
   logic [IDX_W-1:0]       w_pick_idx;
   logic [IDX_W-1:0]       w_base;
   logic [IDX_W-1:0]       w_next_ptr;
   logic                   w_owner_release;
   logic                   w_competitor;

   assign w_base          = (ARB_MODE == ARB_RR) ? r_rr_ptr : '0;
   assign w_owner_release = !M_Req[r_owner] && M_Idle[r_owner];
   assign w_competitor    = |(M_Req & ~r_grant);
   assign w_next_ptr      = (w_pick_idx == IDX_W'(NUM_MASTERS - 1)) ? '0
                                                                    : w_pick_idx + IDX_W'(1);

   arb_picker #(
      .NUM_MASTERS (NUM_MASTERS)
   ) u_picker (
      .i_req   (M_Req),
      .i_base  (w_base),
      .o_valid (w_pick_valid),
      .o_index (w_pick_idx)
   );

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:     if (w_pick_valid) w_next_state = GRANT;
         GRANT:    if (w_owner_release) w_next_state = HANDOVER;
         HANDOVER: w_next_state = w_pick_valid ? GRANT : IDLE;
         default:  w_next_state = IDLE;
      endcase
   end

   // Yield is sticky for the rest of the tenure once raised.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_state    <= IDLE;
         r_owner    <= '0;
         r_rr_ptr   <= '0;
         r_hold_cnt <= '0;
         r_grant    <= '0;
         r_yield    <= '0;
      end else begin
         r_state <= w_next_state;
         if (w_next_state == GRANT && r_state != GRANT) begin
            r_owner    <= w_pick_idx;
            r_grant    <= NUM_MASTERS'(1) << w_pick_idx;
            r_rr_ptr   <= w_next_ptr;
            r_hold_cnt <= '0;
            r_yield    <= '0;
         end else if (w_next_state == GRANT) begin
            if (r_hold_cnt != HOLD_MAX) begin
               r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
            end
            if (MAX_HOLD != 0 && r_hold_cnt == HOLD_MAX && w_competitor) begin
               r_yield <= r_grant;
            end
         end else begin
            r_owner    <= '0;
            r_grant    <= '0;
            r_yield    <= '0;
            r_hold_cnt <= '0;
         end
      end
   end

   // Only the owner's pins reach the RAM; everyone else is ignored.
   always_comb begin
      RAM_Address = '0;
      RAM_DataIn  = '0;
      RAM_Cs      = RAM_CS_OFF;
      RAM_Wen     = RAM_WEN_OFF;
      RAM_Oen     = RAM_OEN_OFF;
      if (r_state == GRANT) begin
         RAM_Address = M_Address[int'(r_owner)*ADDR_W +: ADDR_W];
         RAM_DataIn  = M_DataOut[int'(r_owner)*DATA_W +: DATA_W];
         RAM_Cs      = M_Cs[r_owner];
         RAM_Wen     = M_Wen[r_owner];
         RAM_Oen     = M_Oen[r_owner];
      end
   end

   assign M_Grant     = r_grant;
   assign M_Yield     = r_yield;
   assign Owner       = r_owner;
   assign Busy        = (r_state == GRANT);
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ram_arbiter_mm.sv
// Directed bench: a fixed-priority instance (hold limit 5) and a
// round-robin instance (no hold limit) share one set of master inputs.
module tb_ram_arbiter_mm;
   import ram_arb_pkg::*;

   logic        clk;
   logic        rst;
   logic [3:0]  req, idle, cs, wen, oen;
   logic [31:0] addr_bus, data_bus;

   logic [3:0]  f_grant, f_yield;
   logic [7:0]  f_addr, f_data;
   logic        f_cs, f_wen, f_oen, f_busy;
   logic [1:0]  f_owner, f_dbg;

   logic [3:0]  rr_grant, rr_yield;
   logic [7:0]  rr_addr, rr_data;
   logic        rr_cs, rr_wen, rr_oen, rr_busy;
   logic [1:0]  rr_owner, rr_dbg;

   int n_total = 0;
   int n_pass  = 0;

   ram_arbiter_mm #(
      .NUM_MASTERS (4), .ADDR_W (8), .DATA_W (8),
      .ARB_MODE    (ARB_FIXED), .MAX_HOLD (5)
   ) u_fix (
      .Clk (clk), .Rst (rst), .M_Req (req), .M_Idle (idle),
      .M_Grant (f_grant), .M_Yield (f_yield),
      .M_Address (addr_bus), .M_DataOut (data_bus),
      .M_Cs (cs), .M_Wen (wen), .M_Oen (oen),
      .RAM_Address (f_addr), .RAM_DataIn (f_data),
      .RAM_Cs (f_cs), .RAM_Wen (f_wen), .RAM_Oen (f_oen),
      .Owner (f_owner), .Busy (f_busy), .o_dbg_state (f_dbg)
   );

   ram_arbiter_mm #(
      .NUM_MASTERS (4), .ADDR_W (8), .DATA_W (8),
      .ARB_MODE    (ARB_RR), .MAX_HOLD (0)
   ) u_rr (
      .Clk (clk), .Rst (rst), .M_Req (req), .M_Idle (idle),
      .M_Grant (rr_grant), .M_Yield (rr_yield),
      .M_Address (addr_bus), .M_DataOut (data_bus),
      .M_Cs (cs), .M_Wen (wen), .M_Oen (oen),
      .RAM_Address (rr_addr), .RAM_DataIn (rr_data),
      .RAM_Cs (rr_cs), .RAM_Wen (rr_wen), .RAM_Oen (rr_oen),
      .Owner (rr_owner), .Busy (rr_busy), .o_dbg_state (rr_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   typedef struct {
      logic [3:0] req, idle, cs, wen;
      logic [3:0] exp_grant;
      logic [1:0] exp_owner;
      logic       exp_busy;
      logic [7:0] exp_addr, exp_data;
      logic       exp_cs, exp_wen;
   } vec_t;

   vec_t vecs[18];
   int   order[5];

   initial begin
      // req, idle, cs, wen | grant, owner, busy, addr, data, cs, wen (fixed instance)
      vecs[0]  = '{4'b1010, 4'b1111, 4'b0010, 4'b1111, 4'b0010, 2'd1, 1'b1, 8'h3C, 8'hA1, 1'b1, 1'b1};
      vecs[1]  = '{4'b1000, 4'b1101, 4'b0010, 4'b1101, 4'b0010, 2'd1, 1'b1, 8'h3C, 8'hA1, 1'b1, 1'b0};
      vecs[2]  = '{4'b1000, 4'b1101, 4'b0010, 4'b1101, 4'b0010, 2'd1, 1'b1, 8'h3C, 8'hA1, 1'b1, 1'b0};
      vecs[3]  = '{4'b1000, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 2'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1};
      vecs[4]  = '{4'b1000, 4'b1111, 4'b0000, 4'b1111, 4'b1000, 2'd3, 1'b1, 8'hC3, 8'hA3, 1'b0, 1'b1};
      vecs[5]  = '{4'b1001, 4'b1111, 4'b1001, 4'b0111, 4'b1000, 2'd3, 1'b1, 8'hC3, 8'hA3, 1'b1, 1'b0};
      vecs[6]  = '{4'b0001, 4'b1111, 4'b0001, 4'b1110, 4'b0000, 2'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1};
      vecs[7]  = '{4'b0001, 4'b1111, 4'b0001, 4'b1110, 4'b0001, 2'd0, 1'b1, 8'h10, 8'hA0, 1'b1, 1'b0};
      vecs[8]  = '{4'b1001, 4'b1111, 4'b1001, 4'b0111, 4'b0001, 2'd0, 1'b1, 8'h10, 8'hA0, 1'b1, 1'b1};
      vecs[9]  = '{4'b1000, 4'b1111, 4'b1000, 4'b0111, 4'b0000, 2'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1};
      vecs[10] = '{4'b1000, 4'b1111, 4'b1000, 4'b0111, 4'b1000, 2'd3, 1'b1, 8'hC3, 8'hA3, 1'b1, 1'b0};
      vecs[11] = '{4'b0000, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 2'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1};
      vecs[12] = '{4'b0000, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 2'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1};
      vecs[13] = '{4'b0100, 4'b1111, 4'b0000, 4'b1111, 4'b0100, 2'd2, 1'b1, 8'h5A, 8'hA2, 1'b0, 1'b1};
      vecs[14] = '{4'b0000, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 2'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1};
      vecs[15] = '{4'b0100, 4'b1111, 4'b0100, 4'b1111, 4'b0100, 2'd2, 1'b1, 8'h5A, 8'hA2, 1'b1, 1'b1};
      vecs[16] = '{4'b0011, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 2'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1};
      vecs[17] = '{4'b0011, 4'b1111, 4'b0001, 4'b1111, 4'b0001, 2'd0, 1'b1, 8'h10, 8'hA0, 1'b1, 1'b1};
      order = '{0, 1, 2, 3, 0};

      rst      = 1'b1;
      req      = 4'b0000;
      idle     = 4'b1111;
      cs       = 4'b0000;
      wen      = 4'b1111;
      oen      = 4'b1111;
      addr_bus = {8'hC3, 8'h5A, 8'h3C, 8'h10};
      data_bus = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      tick();
      tick();

      // reset state
      chk("rst grant",  f_grant, 4'b0000);
      chk("rst yield",  f_yield, 4'b0000);
      chk("rst owner",  f_owner, 2'd0);
      chk("rst busy",   f_busy, 1'b0);
      chk("rst cs",     f_cs, 1'b0);
      chk("rst wen",    f_wen, 1'b1);
      chk("rst oen",    f_oen, 1'b1);
      chk("rst addr",   f_addr, 8'h00);
      chk("rst state",  f_dbg, IDLE);
      chk("rst rr grant", rr_grant, 4'b0000);
      rst = 1'b0;

      // fixed-priority vector table
      for (int i = 0; i < 18; i++) begin
         req  = vecs[i].req;
         idle = vecs[i].idle;
         cs   = vecs[i].cs;
         wen  = vecs[i].wen;
         tick();
         chk($sformatf("v%0d grant", i), f_grant, vecs[i].exp_grant);
         chk($sformatf("v%0d owner", i), f_owner, vecs[i].exp_owner);
         chk($sformatf("v%0d busy", i),  f_busy,  vecs[i].exp_busy);
         chk($sformatf("v%0d addr", i),  f_addr,  vecs[i].exp_addr);
         chk($sformatf("v%0d data", i),  f_data,  vecs[i].exp_data);
         chk($sformatf("v%0d cs", i),    f_cs,    vecs[i].exp_cs);
         chk($sformatf("v%0d wen", i),   f_wen,   vecs[i].exp_wen);
         chk($sformatf("v%0d yield", i), f_yield, 4'b0000);
      end

      // asynchronous reset while master 2 is writing
      req = 4'b0000; cs = 4'b0000; wen = 4'b1111;
      tick(); tick(); tick();
      req = 4'b0100; cs = 4'b0100; wen = 4'b1011;
      tick();
      chk("pre-rst grant", f_grant, 4'b0100);
      chk("pre-rst cs",    f_cs, 1'b1);
      chk("pre-rst wen",   f_wen, 1'b0);
      chk("pre-rst rr grant", rr_grant, 4'b0100);
      #2;
      rst = 1'b1;
      #1;
      chk("async rst grant", f_grant, 4'b0000);
      chk("async rst cs",    f_cs, 1'b0);
      chk("async rst wen",   f_wen, 1'b1);
      chk("async rst rr grant", rr_grant, 4'b0000);
      tick();
      rst = 1'b0;
      req = 4'b1111; cs = 4'b0000; wen = 4'b1111;
      tick();
      chk("post-rst fixed grant", f_grant, 4'b0001);

      // round-robin: all request, each owner holds three cycles then releases
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("rr%0d grant a", k), rr_grant, 4'b0001 << order[k]);
         chk($sformatf("rr%0d owner", k),   rr_owner, order[k]);
         tick();
         chk($sformatf("rr%0d grant b", k), rr_grant, 4'b0001 << order[k]);
         tick();
         chk($sformatf("rr%0d grant c", k), rr_grant, 4'b0001 << order[k]);
         req = 4'b1111 & ~(4'b0001 << order[k]);
         tick();
         chk($sformatf("rr%0d dead grant", k), rr_grant, 4'b0000);
         chk($sformatf("rr%0d dead state", k), rr_dbg, HANDOVER);
         req = 4'b1111;
         tick();
      end

      // hold limit: master 0 holds, master 2 joins at cycle 2
      rst = 1'b1;
      tick();
      rst = 1'b0;
      req = 4'b0001;
      tick();
      for (int c = 0; c < 10; c++) begin
         if (c == 2) req = 4'b0101;
         chk($sformatf("hold c%0d grant", c), f_grant, 4'b0001);
         chk($sformatf("hold c%0d yield", c), f_yield, (c >= 6) ? 4'b0001 : 4'b0000);
         if (c == 9) chk("rr no-limit yield", rr_yield, 4'b0000);
         tick();
      end
      req = 4'b0100;
      tick();
      chk("hold release grant", f_grant, 4'b0000);
      chk("hold release yield", f_yield, 4'b0000);
      tick();
      chk("hold next grant", f_grant, 4'b0100);
      chk("hold next owner", f_owner, 2'd2);
      chk("hold next yield", f_yield, 4'b0000);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/ram_arbiter_mm.md
# ram_arbiter_mm

Parametrised multi-master RAM arbiter, the successor of the two-master CPU/DMA arbiter in the ucontroller top level. It accepts up to NUM_MASTERS bus requesters (CPU, DMA channels, future peripherals), grants the single-port RAM to one at a time under fixed-priority or round-robin policy, and inserts a dead cycle at every ownership change. An optional hold limit signals the current owner to yield when others are waiting.

## Interface
- NUM_MASTERS, 4, number of requesters, 2..8
- ADDR_W, 8, RAM address width
- DATA_W, 8, RAM data width
- ARB_MODE, ARB_FIXED, arbitration policy: ARB_FIXED (lowest index wins) or ARB_RR (round-robin)
- MAX_HOLD, 0, grant cycles before Yield is raised; 0 disables

- Clk  in  1  single clock, rising edge
- Rst  in  1  asynchronous, active-high reset
- M_Req  in  NUM_MASTERS  per-master bus request
- M_Idle  in  NUM_MASTERS  per-master "no RAM transaction in flight"
- M_Grant  out  NUM_MASTERS  one-hot registered grant
- M_Yield  out  NUM_MASTERS  registered request to the owner to release
- M_Address  in  NUM_MASTERS*ADDR_W  packed addresses, master i at [i*ADDR_W +: ADDR_W]
- M_DataOut  in  NUM_MASTERS*DATA_W  packed write data
- M_Cs / M_Wen / M_Oen  in  NUM_MASTERS each  chip select (active-high), write/output enable (active-low)
- RAM_Address  out  ADDR_W  muxed address
- RAM_DataIn  out  DATA_W  muxed write data
- RAM_Cs / RAM_Wen / RAM_Oen  out  1 each  muxed strobes
- Owner  out  $clog2(NUM_MASTERS)  index of current owner, 0 when none
- Busy  out  1  high in GRANT

## Operation
- States: IDLE, GRANT, HANDOVER.
- IDLE: no grant; RAM_Cs=0, RAM_Wen=1, RAM_Oen=1, RAM_Address=0, RAM_DataIn=0. Any M_Req -> pick winner, go GRANT.
- Winner: ARB_FIXED -> lowest set index. ARB_RR -> first set index at or after rr_ptr, wrapping; on each grant rr_ptr <= winner+1 mod NUM_MASTERS.
- GRANT: M_Grant[Owner]=1; RAM outputs driven combinationally from master Owner's inputs. Exit only when M_Req[Owner]=0 AND M_Idle[Owner]=1 -> HANDOVER. Req dropped while Idle=0: grant held. Idle=1 while Req=1: grant held.
- HANDOVER: one cycle, grants and strobes inactive as in IDLE. Next: any request pending -> GRANT with new winner (former owner eligible only under normal policy rules); else IDLE.
- Hold counter: cleared on entering GRANT, increments each GRANT cycle, saturates at MAX_HOLD. When MAX_HOLD≠0, count==MAX_HOLD and any other M_Req set -> M_Yield[Owner]=1 until GRANT exits. Yield is advisory; no forced preemption.
- Non-granted masters' strobes are ignored entirely.

## Timing
- Reset (async, Rst=1): state IDLE, M_Grant=0, M_Yield=0, Owner=0, Busy=0, rr_ptr=0, counter 0, RAM outputs as in IDLE. Mid-transaction reset drops grants immediately.
- Request latency: M_Req sampled high at edge t in IDLE -> M_Grant high after edge t (visible cycle t+1).
- Release: Req=0 & Idle=1 sampled at edge t -> grant low from cycle t+1 (HANDOVER), next grant from cycle t+2.
- Back-to-back ownership: minimum one dead cycle between owners; a single master re-requesting also sees the dead cycle.
- Simultaneous requests: resolved in the same cycle by policy; exactly one grant bit ever set.
- Yield asserts the cycle after the counter reaches MAX_HOLD with a competitor pending.

## Structure
- Package ram_arb_pkg: arb_mode_e {ARB_FIXED, ARB_RR}, arb_state_e {IDLE, GRANT, HANDOVER}, inactive strobe constants.
- Sub-module arb_picker: combinational rotating-base priority encoder (requests, base) -> (valid, index); fixed mode uses base 0.

## Test plan
- Reset mid-GRANT with master 2 writing: Rst pulse -> M_Grant=0, RAM_Cs=0, RAM_Wen=1 immediately; post-reset rr_ptr=0.
- ARB_FIXED, M_Req=4'b1010 in IDLE -> M_Grant=4'b0010 next cycle, Owner=1; RAM_Address equals master 1's address 8'h3C.
- ARB_RR, all four request continuously, each releases after 3 cycles -> grant order 0,1,2,3,0 with one dead cycle between.
- Owner 1 drops Req with Idle=0 for 2 cycles -> grant held, then Idle=1 -> HANDOVER, master 3 granted two cycles later.
- MAX_HOLD=5, master 0 holds, master 2 requests at cycle 2 -> M_Yield[0]=1 from cycle 6; no grant change until master 0 releases.
- Master 3 drives M_Cs=1, M_Wen=0 while master 0 owns -> RAM strobes follow master 0 only; no write from master 3.
